spart_baud_gen: RTL and testbench



---
 rtl/spart_pkg.sv | 22 ++
 rtl/spart_baud_gen_if.sv | 11 +
 rtl/spart_tick_div.sv | 40 ++++
 rtl/spart_baud_gen.sv | 77 +++++++
 tb/tb_spart_baud_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register map, baud generator states and a
// counter-width helper reused by the tx/rx/bus blocks.
package spart_pkg;

  typedef enum logic [1:0] {
    IO_XFER   = 2'b00,
    REG_RD    = 2'b01,
    LD_DIV_LO = 2'b10,
    LD_DIV_HI = 2'b11
  } ioaddr_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } baud_state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spart_baud_gen_if.sv
// SPART I/O bus as seen by the baud generator: the bus decode drives it,
// the generator only listens.
interface spart_baud_gen_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] divisor_part;

  modport master (output iocs, iorw, ioaddr, divisor_part);
  modport slave  (input  iocs, iorw, ioaddr, divisor_part);
endinterface

// File: rtl/spart_tick_div.sv
// Generic modulo-N strobe divider: registered one-cycle strobe on every N-th
// input tick, with a synchronous clear that restarts the count.
module spart_tick_div
  import spart_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  output logic strobe_o
);

  localparam int unsigned    CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic          strobe_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= tick_i && (cnt_q == LAST);
      if (tick_i) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/spart_baud_gen.sv
// SPART baud-rate generator: programmable divisor loaded as LO/HI bytes,
// RX oversample strobe every divisor+1 clocks, TX strobe every OVERSAMPLE RX strobes.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned RESET_DIV  = 0
) (
  input  logic             clk,
  input  logic             rst,
  spart_baud_gen_if.slave  bus,
  output logic             rx_en,
  output logic             tx_en,
  output logic             running,
  output logic [DIV_W-1:0] divisor_q
);

  localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);

  logic [7:0]       div_lo_q;
  logic [DIV_W-1:0] period_cnt_q;
  baud_state_e      state_q;
  logic             rx_en_q;

  logic             wr;
  logic             lo_wr;
  logic             commit;
  logic             rx_tick;
  logic [DIV_W-1:0] new_div;

  assign wr      = bus.iocs & ~bus.iorw;
  assign lo_wr   = wr && (ioaddr_e'(bus.ioaddr) == LD_DIV_LO);
  assign commit  = wr && (ioaddr_e'(bus.ioaddr) == LD_DIV_HI);
  assign new_div = {bus.divisor_part[DIV_W-9:0], div_lo_q};

  // A commit in the terminal-count cycle wins: the pending tick is dropped.
  assign rx_tick = (state_q == RUN) && (period_cnt_q == '0) && !commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_lo_q     <= '0;
      divisor_q    <= RESET_DIV_V;
      period_cnt_q <= RESET_DIV_V;
      state_q      <= (RESET_DIV_V != '0) ? RUN : IDLE;
      rx_en_q      <= 1'b0;
    end else begin
      if (lo_wr) begin
        div_lo_q <= bus.divisor_part;
      end
      rx_en_q <= rx_tick;
      if (commit) begin
        divisor_q    <= new_div;
        period_cnt_q <= new_div;
        state_q      <= (new_div != '0) ? RUN : IDLE;
      end else if (state_q == RUN) begin
        period_cnt_q <= (period_cnt_q == '0) ? divisor_q
                                             : period_cnt_q - DIV_W'(1);
      end
    end
  end

  // The oversample stage restarts on every commit so TX phase follows the new rate.
  spart_tick_div #(
    .N (OVERSAMPLE)
  ) u_os_div (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (commit),
    .tick_i   (rx_tick),
    .strobe_o (tx_en)
  );

  assign rx_en   = rx_en_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_spart_baud_gen.sv
// Self-checking bench for spart_baud_gen: a closed-form pulse-timing model
// feeds a scoreboard queue that is drained one clock later.
module tb_spart_baud_gen;

  localparam int unsigned OS0 = 4;
  localparam int unsigned DW0 = 16;
  localparam int unsigned OS1 = 2;
  localparam int unsigned DW1 = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spart_baud_gen_if bus0 ();
  spart_baud_gen_if bus1 ();

  logic           rx_en0, tx_en0, running0;
  logic [DW0-1:0] divisor0;
  logic           rx_en1, tx_en1, running1;
  logic [DW1-1:0] divisor1;

  spart_baud_gen #(.DIV_W(DW0), .OVERSAMPLE(OS0), .RESET_DIV(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .rx_en(rx_en0), .tx_en(tx_en0), .running(running0), .divisor_q(divisor0)
  );

  spart_baud_gen #(.DIV_W(DW1), .OVERSAMPLE(OS1), .RESET_DIV(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .rx_en(rx_en1), .tx_en(tx_en1), .running(running1), .divisor_q(divisor1)
  );

  // k counts clock edges since the last commit (or reset release).
  typedef struct {
    int unsigned lo;
    int unsigned div;
    int unsigned k;
    bit          run;
  } model_t;

  typedef struct {
    bit          rx0, tx0, run0;
    int unsigned div0;
    bit          rx1, tx1, run1;
    int unsigned div1;
  } exp_t;

  exp_t        sb_q[$];
  model_t      m0, m1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic model_t model_step(input model_t m, input bit lo_wr, input bit commit,
                                        input logic [7:0] data, input int unsigned dw,
                                        input int unsigned os, output bit rx, output bit tx);
    model_t n;
    n  = m;
    rx = 1'b0;
    tx = 1'b0;
    if (lo_wr) n.lo = int'(data);
    if (commit) begin
      n.div = ((int'(data) & ((1 << (dw - 8)) - 1)) << 8) | m.lo;
      n.run = (n.div != 0);
      n.k   = 0;
    end else if (m.run) begin
      n.k = m.k + 1;
      if (n.k % (m.div + 1) == 0) begin
        rx = 1'b1;
        tx = ((n.k / (m.div + 1)) % os) == 0;
      end
    end
    return n;
  endfunction

  task automatic compare_exp(input exp_t e);
    check("d0_rx_en",   32'(rx_en0),   32'(e.rx0));
    check("d0_tx_en",   32'(tx_en0),   32'(e.tx0));
    check("d0_running", 32'(running0), 32'(e.run0));
    check("d0_divisor", 32'(divisor0), e.div0);
    check("d1_rx_en",   32'(rx_en1),   32'(e.rx1));
    check("d1_tx_en",   32'(tx_en1),   32'(e.tx1));
    check("d1_running", 32'(running1), 32'(e.run1));
    check("d1_divisor", 32'(divisor1), e.div1);
  endtask

  // Predict outputs after the coming edge for the inputs just driven.
  task automatic push_expect(input bit lo_wr, input bit commit, input logic [7:0] data);
    exp_t e;
    bit   rx, tx;
    m0     = model_step(m0, lo_wr, commit, data, DW0, OS0, rx, tx);
    e.rx0  = rx;
    e.tx0  = tx;
    e.run0 = m0.run;
    e.div0 = m0.div;
    m1     = model_step(m1, 1'b0, 1'b0, 8'h00, DW1, OS1, rx, tx);
    e.rx1  = rx;
    e.tx1  = tx;
    e.run1 = m1.run;
    e.div1 = m1.div;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit cs, input bit rw, input logic [1:0] addr, input logic [7:0] data);
    bit wr;
    @(negedge clk);
    if (sb_q.size() != 0) compare_exp(sb_q.pop_front());
    bus0.iocs         = cs;
    bus0.iorw         = rw;
    bus0.ioaddr       = addr;
    bus0.divisor_part = data;
    wr = cs && !rw;
    push_expect(wr && (addr == 2'b10), wr && (addr == 2'b11), data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic wr_lo(input logic [7:0] d);
    step(1'b1, 1'b0, 2'b10, d);
  endtask

  task automatic wr_hi(input logic [7:0] d);
    step(1'b1, 1'b0, 2'b11, d);
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic apply_reset();
    @(negedge clk);
    if (sb_q.size() != 0) compare_exp(sb_q.pop_front());
    bus0.iocs         = 1'b0;
    bus0.iorw         = 1'b0;
    bus0.ioaddr       = 2'b00;
    bus0.divisor_part = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_d0_rx_en",   32'(rx_en0),   32'd0);
    check("rst_d0_tx_en",   32'(tx_en0),   32'd0);
    check("rst_d0_running", 32'(running0), 32'd0);
    check("rst_d0_divisor", 32'(divisor0), 32'd0);
    check("rst_d1_rx_en",   32'(rx_en1),   32'd0);
    check("rst_d1_tx_en",   32'(tx_en1),   32'd0);
    check("rst_d1_running", 32'(running1), 32'd1);
    check("rst_d1_divisor", 32'(divisor1), 32'd3);
    m0 = '{lo: 0, div: 0, k: 0, run: 1'b0};
    m1 = '{lo: 0, div: 3, k: 0, run: 1'b1};
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_d1_rx_en", 32'(rx_en1), 32'd0);
    rst = 1'b1;
    push_expect(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus0.iocs = 1'b0; bus0.iorw = 1'b0; bus0.ioaddr = 2'b00; bus0.divisor_part = 8'h00;
    bus1.iocs = 1'b0; bus1.iorw = 1'b0; bus1.ioaddr = 2'b00; bus1.divisor_part = 8'h00;

    // Reset state, then a generator with no divisor stays silent.
    apply_reset();
    idle(200);

    // Divisor 4: rx every 5 clocks, tx every 20.
    wr_lo(8'h04);
    wr_hi(8'h00);
    idle(62);

    // LO alone keeps the old rate; HI commits 9 and restarts both stages.
    wr_lo(8'h09);
    idle(12);
    wr_hi(8'h00);
    idle(45);

    // Commit landing on a terminal count: the pending strobe must be dropped.
    wr_lo(8'h06);
    for (int i = 0; i < 20 && ((m0.k + 1) % (m0.div + 1)) != 0; i++) idle(1);
    wr_hi(8'h00);
    idle(40);

    // Reads, deselected writes and other addresses change nothing.
    step(1'b1, 1'b1, 2'b11, 8'hAA);
    step(1'b0, 1'b0, 2'b11, 8'hAA);
    step(1'b1, 1'b0, 2'b00, 8'h55);
    step(1'b1, 1'b0, 2'b01, 8'h55);
    idle(10);

    // High byte lands in the upper divisor bits.
    wr_lo(8'h02);
    wr_hi(8'h01);
    idle(6);

    // Zero stops the generator; divisor 1 gives rx every other clock.
    wr_lo(8'h00);
    wr_hi(8'h00);
    idle(20);
    wr_lo(8'h01);
    wr_hi(8'h00);
    idle(15);
    wr_hi(8'h00);
    idle(15);

    // Reset in the middle of a period; the stale LO stage is cleared too.
    wr_lo(8'h05);
    wr_hi(8'h00);
    idle(3);
    apply_reset();
    idle(40);
    wr_hi(8'h00);
    idle(20);

    @(negedge clk);
    while (sb_q.size() != 0) compare_exp(sb_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
